bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter that runs the shift-and-add-3 (double-dabble) algorithm one bit per clock. It replaces the fixed 8-bit combinational converter wherever wider operands or a registered, handshaked result are needed, such as display drivers and status readouts. It reports an overflow flag when the chosen digit count cannot hold the input value.

## Interface
- BIN_W, default 8: binary input width, 2 to 32.
- DIGITS, default 3: number of BCD output digits, 1 to 10.
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: synchronous, active-high reset.
- start  input  1: request a conversion; sampled only while busy=0.
- bin  input  BIN_W: unsigned operand; captured on the edge that accepts start.
- busy  output  1: conversion in progress.
- done  output  1: one-cycle pulse when bcd/overflow update.
- bcd  output  4*DIGITS: result; digit i at [4i+3:4i]; digit 0 is the ones digit.
- overflow  output  1: the input value was at least 10^DIGITS; qualified by done, held with bcd.

## Operation
- States: IDLE, SHIFT.
- IDLE with start=1:
  - Load the shift register with bin.
  - Clear the BCD working register and the overflow accumulator.
  - Set the bit counter to 0 and go to SHIFT.
- IDLE with start=0: hold all state.
- SHIFT, each cycle:
  - Correct every working digit: a digit >= 5 gets +3 (4-bit add, no carry out).
  - Shift the corrected digits left by 1, taking the binary MSB in at bit 0.
  - Shift the binary register left by 1.
  - OR the bit shifted out of the top digit into the overflow accumulator.
  - Increment the counter.
- After the shift with counter = BIN_W-1:
  - Write the shifted working value to bcd and the accumulator to overflow.
  - Pulse done and return to IDLE.
- On overflow, bcd = bin mod 10^DIGITS, in valid BCD.
- When DIGITS covers 2^BIN_W-1, overflow is never set.
- start while busy=1 is ignored. It is not queued and bin is not sampled.
- bcd and overflow change only on a done cycle or on reset. They hold between conversions.
- Working registers are internal; partial results never appear on bcd.

## Timing
- Reset values: busy=0, done=0, bcd=0, overflow=0, state IDLE, counter=0.
- Reset mid-conversion: the next edge forces the reset values, the conversion is abandoned, and no done pulse is produced.
- Reset has priority over start on the same edge.
- Edge numbering: start is accepted on edge 0.
  - busy=1 in the cycles after edges 0 through BIN_W-1.
  - The last shift happens on edge BIN_W.
  - In the cycle after edge BIN_W: done=1, busy=0, bcd/overflow valid.
- Latency: BIN_W+1 edges from start acceptance to done.
- done lasts exactly one cycle.
- start held high during the done cycle is accepted, because busy=0. Back-to-back throughput is one result per BIN_W+1 cycles.
- busy is registered and does not depend combinationally on start.
- All outputs are registered.

## Test plan
- BIN_W=8, DIGITS=3, bin=255, start for 1 cycle:
  - busy for 8 cycles, then done for 1 cycle in the cycle after edge 8.
  - bcd=12'h255, overflow=0.
- Same config, bin=0, then bin=99 back-to-back with start held through the done cycle:
  - bcd=12'h000, then 12'h099.
  - The second done comes exactly 9 cycles after the first.
- BIN_W=8, DIGITS=2:
  - bin=100 -> bcd=8'h00, overflow=1.
  - bin=255 -> bcd=8'h55, overflow=1.
  - bin=99 -> bcd=8'h99, overflow=0.
- BIN_W=8, DIGITS=3: bin=37 accepted, then start with bin=200 at cycles 2 and 5:
  - Single done with bcd=12'h037.
  - No second done follows.
- rst asserted at cycle 4 of a conversion of bin=123:
  - Next cycle: busy=0, bcd=0, overflow=0, and no done pulse.
  - A fresh start with bin=123 yields bcd=12'h123.
- BIN_W=16, DIGITS=5: bin=65535 -> bcd=20'h65535 after 17 edges, overflow=0. Exhaustive BIN_W=8 sweep against a behavioural reference.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter, one bit per clock
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [BIN_W-1:0]      bin_sr_q, bin_sr_d;
  logic [4*DIGITS-1:0]   work_q, work_d;
  logic                  ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;

  logic [4*DIGITS-1:0]   corr;
  logic [4*DIGITS-1:0]   shifted;
  logic                  out_bit;

  // Add-3 correction on every digit, then shift the next binary bit in at the bottom.
  always_comb begin
    corr = '0;
    for (int i = 0; i < DIGITS; i++) begin
      corr[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3
                                                   : work_q[4*i +: 4];
    end
    out_bit = corr[4*DIGITS-1];
    shifted = {corr[4*DIGITS-2:0], bin_sr_q[BIN_W-1]};
  end

  always_comb begin
    state_d    = state_q;
    bin_sr_d   = bin_sr_q;
    work_d     = work_q;
    ovf_acc_d  = ovf_acc_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_sr_d  = bin;
          work_d    = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        work_d    = shifted;
        bin_sr_d  = bin_sr_q << 1;
        ovf_acc_d = ovf_acc_q | out_bit;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          bcd_d      = shifted;
          overflow_d = ovf_acc_q | out_bit;
          done_d     = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_sr_q   <= '0;
      work_q     <= '0;
      ovf_acc_q  <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_sr_q   <= bin_sr_d;
      work_q     <= work_d;
      ovf_acc_q  <= ovf_acc_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a = 1'b0;
  logic [7:0]  bin_a = '0;
  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;

  logic        start_b = 1'b0;
  logic [7:0]  bin_b = '0;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;

  logic        start_c = 1'b0;
  logic [15:0] bin_c = '0;
  logic        busy_c, done_c, ovf_c;
  logic [19:0] bcd_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion on u_a and wait (bounded) for its done pulse.
  task automatic run_a(input logic [7:0] v, output logic [11:0] r, output logic o,
                       output logic got);
    bin_a = v; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (done_a) got = 1'b1;
    end
    r = bcd_a; o = ovf_a;
  endtask

  task automatic run_b(input logic [7:0] v, output logic [7:0] r, output logic o,
                       output logic got);
    bin_b = v; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (done_b) got = 1'b1;
    end
    r = bcd_b; o = ovf_b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if ({busy_a, done_a, ovf_a, bcd_a} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_a: got busy=%b done=%b ovf=%b bcd=%h, want all 0",
               busy_a, done_a, ovf_a, bcd_a);
    end
    n_tests++;
    if ({busy_b, done_b, ovf_b, bcd_b, busy_c, done_c, ovf_c, bcd_c} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_bc: got bcd_b=%h bcd_c=%h busy_b=%b busy_c=%b, want all 0",
               bcd_b, bcd_c, busy_b, busy_c);
    end
  endtask

  task automatic test_latency_255();
    int bad = 0;
    bin_a = 8'd255; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    bin_a = 8'd0;
    for (int e = 0; e < 8; e++) begin
      if (busy_a !== 1'b1 || done_a !== 1'b0) bad++;
      if (e < 7) tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_window: %0d cycles wrong out of 8, want busy=1 done=0", bad);
    end
    tick();
    n_tests++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || bcd_a !== 12'h255 || ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL conv_255: got done=%b busy=%b bcd=%h ovf=%b, want 1 0 255 0",
               done_a, busy_a, bcd_a, ovf_a);
    end
    tick();
    n_tests++;
    if (done_a !== 1'b0 || bcd_a !== 12'h255) begin
      n_fail++;
      $display("FAIL done_width: got done=%b bcd=%h, want done=0 bcd=255 held", done_a, bcd_a);
    end
  endtask

  task automatic test_back_to_back();
    int t = 0, t1 = -1, t2 = -1;
    logic [11:0] r1 = '0;
    bin_a = 8'd0; start_a = 1'b1;
    tick();
    bin_a = 8'd99;
    while (t < 40 && t2 < 0) begin
      tick(); t++;
      if (done_a) begin
        if (t1 < 0) begin t1 = t; r1 = bcd_a; end
        else begin t2 = t; start_a = 1'b0; end
      end
    end
    start_a = 1'b0;
    n_tests++;
    if (t1 < 0 || r1 !== 12'h000) begin
      n_fail++;
      $display("FAIL b2b_first: got bcd=%h seen=%0d, want 000", r1, t1);
    end
    n_tests++;
    if (t2 < 0 || bcd_a !== 12'h099) begin
      n_fail++;
      $display("FAIL b2b_second: got bcd=%h seen=%0d, want 099", bcd_a, t2);
    end
    n_tests++;
    if (t2 - t1 !== 9) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles, want 9", t2 - t1);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] r; logic o, got;
    logic [7:0] vin [3] = '{8'd100, 8'd255, 8'd99};
    logic [7:0] vexp[3] = '{8'h00, 8'h55, 8'h99};
    logic       oexp[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_b(vin[i], r, o, got);
      n_tests++;
      if (!got || r !== vexp[i] || o !== oexp[i]) begin
        n_fail++;
        $display("FAIL ovf_d2_%0d: got bcd=%h ovf=%b done_seen=%b, want bcd=%h ovf=%b",
                 vin[i], r, o, got, vexp[i], oexp[i]);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    logic [11:0] r = '0;
    bin_a = 8'd37; start_a = 1'b1;
    tick();
    for (int e = 1; e <= 8; e++) begin
      start_a = (e == 2 || e == 5);
      bin_a   = start_a ? 8'd200 : 8'd0;
      tick();
      if (done_a) begin dones++; r = bcd_a; end
    end
    start_a = 1'b0;
    n_tests++;
    if (dones !== 1 || r !== 12'h037) begin
      n_fail++;
      $display("FAIL busy_start: got %0d dones bcd=%h, want 1 done bcd=037", dones, r);
    end
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done_a || busy_a) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL no_queue: got %0d busy/done cycles after, want 0", dones);
    end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    logic [11:0] r; logic o, got;
    bin_a = 8'd123; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || bcd_a !== 12'h000 || ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b done=%b bcd=%h ovf=%b, want 0 0 000 0",
               busy_a, done_a, bcd_a, ovf_a);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done_a) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL abandoned_done: got %0d done pulses, want 0", extra);
    end
    run_a(8'd123, r, o, got);
    n_tests++;
    if (!got || r !== 12'h123 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: got bcd=%h ovf=%b seen=%b, want 123 0", r, o, got);
    end
    tick();
  endtask

  task automatic test_wide();
    int edges = 1;
    logic got = 1'b0;
    bin_c = 16'd65535; start_c = 1'b1;
    tick();
    start_c = 1'b0;
    while (edges < 40 && !got) begin
      tick(); edges++;
      if (done_c) got = 1'b1;
    end
    n_tests++;
    if (!got || edges !== 17 || bcd_c !== 20'h65535 || ovf_c !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_65535: got bcd=%h ovf=%b edges=%0d, want 65535 0 17",
               bcd_c, ovf_c, edges);
    end
    tick();
  endtask

  task automatic test_sweep();
    logic got;
    logic [11:0] ea;
    logic [7:0]  eb;
    logic        eo;
    for (int v = 0; v < 256; v++) begin
      ea = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      eb = {4'((v / 10) % 10), 4'(v % 10)};
      eo = (v >= 100);
      bin_a = 8'(v); bin_b = 8'(v);
      start_a = 1'b1; start_b = 1'b1;
      tick();
      start_a = 1'b0; start_b = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        tick();
        if (done_a) got = 1'b1;
      end
      n_tests++;
      if (!got || bcd_a !== ea || ovf_a !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_d3_%0d: got bcd=%h ovf=%b, want %h 0", v, bcd_a, ovf_a, ea);
      end
      n_tests++;
      if (done_b !== 1'b1 || bcd_b !== eb || ovf_b !== eo) begin
        n_fail++;
        $display("FAIL sweep_d2_%0d: got bcd=%h ovf=%b done=%b, want %h %b",
                 v, bcd_b, ovf_b, done_b, eb, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency_255();
    test_back_to_back();
    test_overflow();
    test_start_ignored();
    test_reset_mid();
    test_wide();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
